// File: rtl/pll_cken_seq.sv
// pll_cken_seq: PLL lock qualification, staged per-channel domain reset
// release and per-channel divided clock enables, all on refclk.
// Optional feature: define PLL_CKEN_LOSS_COUNT_EN to build the saturating
// lock-loss counter behind loss_count; otherwise loss_count is tied to 0.
module pll_cken_seq #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned RELEASE_GAP = 4
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic                    div_load,
    input  logic                    lost_clr,
    output logic [NUM_CH-1:0]       cken,
    output logic [NUM_CH-1:0]       rst_out_n,
    output logic                    locked,
    output logic                    lock_lost,
    output logic [7:0]              loss_count
);

    localparam int unsigned REL_CYCLES = RELEASE_GAP * NUM_CH;
    localparam int unsigned CNT_MAX    = (LOCK_CYCLES > REL_CYCLES) ? LOCK_CYCLES : REL_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RELEASE,
        RUN
    } state_t;

    logic                 sync1_q;
    logic                 lk_q;

    state_t               state_q;
    logic [CNT_W-1:0]     seq_cnt_q;
    logic [NUM_CH-1:0]    rst_out_n_q;
    logic                 locked_q;
    logic                 lock_lost_q;
    logic                 lost_set;

    logic                 idle;
    logic                 running;
    logic [NUM_CH-1:0]    term;
    logic [DIV_W-1:0]     ratio_q    [NUM_CH];
    logic [DIV_W-1:0]     ratio_d    [NUM_CH];
    logic [DIV_W-1:0]     pend_val_q [NUM_CH];
    logic [DIV_W-1:0]     pend_val_d [NUM_CH];
    logic [DIV_W-1:0]     cnt_q      [NUM_CH];
    logic [DIV_W-1:0]     cnt_d      [NUM_CH];
    logic [NUM_CH-1:0]    pend_q;
    logic [NUM_CH-1:0]    pend_d;
    logic [NUM_CH-1:0]    cken_q;
    logic [NUM_CH-1:0]    cken_d;

    // Two-flop synchronizer for the raw PLL lock flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_q    <= sync1_q;
        end
    end

    // A lock loss is only reported when it interrupts RUN.
    assign lost_set = (state_q == RUN) && !lk_q;

    // Sequencer FSM: lock qualification, staged reset release, sticky loss flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            seq_cnt_q   <= '0;
            rst_out_n_q <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            if (lost_set) begin
                lock_lost_q <= 1'b1;
            end else if (lost_clr) begin
                lock_lost_q <= 1'b0;
            end

            if ((state_q != WAIT_LOCK) && !lk_q) begin
                state_q     <= WAIT_LOCK;
                seq_cnt_q   <= '0;
                rst_out_n_q <= '0;
                locked_q    <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_LOCK: begin
                        seq_cnt_q   <= '0;
                        rst_out_n_q <= '0;
                        locked_q    <= 1'b0;
                        if (lk_q) begin
                            state_q <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (seq_cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                            state_q   <= RELEASE;
                            seq_cnt_q <= '0;
                        end else begin
                            seq_cnt_q <= seq_cnt_q + CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (seq_cnt_q == CNT_W'(RELEASE_GAP * (i + 1) - 1)) begin
                                rst_out_n_q[i] <= 1'b1;
                            end
                        end
                        if (seq_cnt_q == CNT_W'(REL_CYCLES - 1)) begin
                            state_q   <= RUN;
                            locked_q  <= 1'b1;
                            seq_cnt_q <= '0;
                        end else begin
                            seq_cnt_q <= seq_cnt_q + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        locked_q    <= 1'b1;
                        rst_out_n_q <= '1;
                    end
                    default: begin
                        state_q <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

    // Channels count only while the sequencer is out of WAIT_LOCK and lock
    // is still present; a lock drop clears counters in the same edge.
    assign idle    = (state_q == WAIT_LOCK);
    assign running = !idle && lk_q;

    // Per-channel divider next state. A pending ratio is adopted only at the
    // terminal count of the current period (or at once while idle), so the
    // period in flight always completes with the ratio it started with.
    always_comb begin
        term   = '0;
        pend_d = pend_q;
        cken_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ratio_d[i]    = ratio_q[i];
            pend_val_d[i] = pend_val_q[i];
            cnt_d[i]      = '0;

            term[i] = running &&
                      ((ratio_q[i] <= DIV_W'(1)) || (cnt_q[i] == ratio_q[i] - DIV_W'(1)));

            if (running && !term[i]) begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
            cken_d[i] = term[i];

            if (idle && div_load) begin
                ratio_d[i] = div[i*DIV_W +: DIV_W];
                pend_d[i]  = 1'b0;
            end else begin
                if (pend_q[i] && (idle || term[i])) begin
                    ratio_d[i] = pend_val_q[i];
                    pend_d[i]  = 1'b0;
                end
                if (div_load) begin
                    pend_val_d[i] = div[i*DIV_W +: DIV_W];
                    pend_d[i]     = 1'b1;
                end
            end
        end
    end

    // Per-channel divider registers; shadow ratios come out of reset at 1.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ratio_q[i]    <= DIV_W'(1);
                pend_val_q[i] <= '0;
                cnt_q[i]      <= '0;
            end
            pend_q <= '0;
            cken_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ratio_q[i]    <= ratio_d[i];
                pend_val_q[i] <= pend_val_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
            pend_q <= pend_d;
            cken_q <= cken_d;
        end
    end

`ifdef PLL_CKEN_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    // Saturating lock-loss counter; a clear coinciding with a new loss
    // leaves a count of one so it agrees with the still-set sticky flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if (lost_set) begin
            if (lost_clr) begin
                loss_cnt_q <= 8'd1;
            end else if (loss_cnt_q != 8'hFF) begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
            end
        end else if (lost_clr) begin
            loss_cnt_q <= '0;
        end
    end

    assign loss_count = loss_cnt_q;
`else
    assign loss_count = '0;
`endif

    assign cken      = cken_q;
    assign rst_out_n = rst_out_n_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_cken_seq.sv
// Testbench for pll_cken_seq (NUM_CH=2, LOCK_CYCLES=16, RELEASE_GAP=4).
// Expected values come from hand-derived tables and from a time-based
// reference model (phase since lock, absolute next-pulse times).
module tb_pll_cken_seq;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int RELEASE_GAP = 4;
    localparam int LR          = LOCK_CYCLES + RELEASE_GAP * NUM_CH;
`ifdef PLL_CKEN_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        pll_locked = 1'b0;
    logic        div_load   = 1'b0;
    logic        lost_clr   = 1'b0;
    logic [15:0] div        = '0;
    logic [1:0]  cken;
    logic [1:0]  rst_out_n;
    logic        locked;
    logic        lock_lost;
    logic [7:0]  loss_count;

    pll_cken_seq #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .RELEASE_GAP (RELEASE_GAP)
    ) dut (
        .refclk     (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .div        (div),
        .div_load   (div_load),
        .lost_clr   (lost_clr),
        .cken       (cken),
        .rst_out_n  (rst_out_n),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: up = cycles since leaving WAIT_LOCK (-1 = waiting)
    int         up;
    logic       pl_d1, pl_d2;
    int         ratio      [NUM_CH];
    int         pend_val   [NUM_CH];
    bit         pend       [NUM_CH];
    int         next_pulse [NUM_CH];
    logic [1:0] m_cken;
    logic       m_lost;
    int         m_count;

    typedef struct {
        int         cyc;
        logic       dl;
        logic [15:0] dv;
        logic [1:0] cken;
        logic [1:0] rst;
        logic       lkd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int eff(input int d);
        return (d <= 1) ? 1 : d;
    endfunction

    task automatic model_reset();
        up    = -1;
        pl_d1 = 1'b0;
        pl_d2 = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ratio[i]      = 1;
            pend_val[i]   = 0;
            pend[i]       = 1'b0;
            next_pulse[i] = 0;
        end
        m_cken  = '0;
        m_lost  = 1'b0;
        m_count = 0;
    endtask

    task automatic model_step(input logic pl, input logic dl, input logic [15:0] dv, input logic clr);
        logic lk;
        bit   ev;
        bit   was_wait;
        int   new_up;
        int   nc;
        lk       = pl_d2;
        pl_d2    = pl_d1;
        pl_d1    = pl;
        ev       = (up >= LR) && !lk;
        was_wait = (up < 0);
        new_up   = lk ? up + 1 : -1;
        nc       = cyc + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            int d_in;
            d_in      = int'(dv[i*8 +: 8]);
            m_cken[i] = 1'b0;
            if (was_wait) begin
                if (dl) begin
                    ratio[i] = d_in;
                    pend[i]  = 1'b0;
                end else if (pend[i]) begin
                    ratio[i] = pend_val[i];
                    pend[i]  = 1'b0;
                end
            end else begin
                if (new_up >= 1 && nc == next_pulse[i]) begin
                    m_cken[i] = 1'b1;
                    if (pend[i]) begin
                        ratio[i] = pend_val[i];
                        pend[i]  = 1'b0;
                    end
                    next_pulse[i] = nc + eff(ratio[i]);
                end
                if (dl) begin
                    pend_val[i] = d_in;
                    pend[i]     = 1'b1;
                end
            end
            if (new_up == 0) next_pulse[i] = nc + eff(ratio[i]);
        end
        if (ev) begin
            m_lost  = 1'b1;
            m_count = clr ? 1 : ((m_count < 255) ? m_count + 1 : 255);
        end else if (clr) begin
            m_lost  = 1'b0;
            m_count = 0;
        end
        up = new_up;
    endtask

    task automatic compare_model();
        logic [1:0] exp_rst;
        for (int i = 0; i < NUM_CH; i++)
            exp_rst[i] = (up >= LOCK_CYCLES + RELEASE_GAP * (i + 1));
        chk("m_cken",      32'(cken),       32'(m_cken));
        chk("m_rst_out_n", 32'(rst_out_n),  32'(exp_rst));
        chk("m_locked",    32'(locked),     32'(up >= LR));
        chk("m_lock_lost", 32'(lock_lost),  32'(m_lost));
        chk("m_loss_cnt",  32'(loss_count), CNT_EN ? 32'(m_count) : 32'd0);
    endtask

    task automatic tick(input logic pl, input logic dl, input logic [15:0] dv, input logic clr);
        pll_locked = pl;
        div_load   = dl;
        div        = dv;
        lost_clr   = clr;
        @(posedge clk);
        #1;
        model_step(pl, dl, dv, clr);
        cyc++;
        compare_model();
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_cken",     32'(cken),       32'd0);
        chk("async_rst_out",  32'(rst_out_n),  32'd0);
        chk("async_locked",   32'(locked),     32'd0);
        chk("async_lost",     32'(lock_lost),  32'd0);
        chk("async_loss_cnt", 32'(loss_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        div_load = 1'b0;
        lost_clr = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic add(input int c, input logic dl, input logic [15:0] dv,
                       input logic [1:0] ck, input logic [1:0] rs, input logic lkd);
        vec_t v;
        v.cyc = c; v.dl = dl; v.dv = dv; v.cken = ck; v.rst = rs; v.lkd = lkd;
        vecs.push_back(v);
    endtask

    // Lock-up timeline, ratio programming and mid-period ratio change
    task automatic run_table();
        logic        dl;
        logic [15:0] dv;
        add(0,  0, 16'h0000, 2'b00, 2'b00, 0);
        add(3,  0, 16'h0000, 2'b00, 2'b00, 0);
        add(4,  0, 16'h0000, 2'b11, 2'b00, 0);
        add(22, 0, 16'h0000, 2'b11, 2'b00, 0);
        add(23, 0, 16'h0000, 2'b11, 2'b01, 0);
        add(26, 0, 16'h0000, 2'b11, 2'b01, 0);
        add(27, 0, 16'h0000, 2'b11, 2'b11, 1);
        add(30, 1, 16'h0502, 2'b11, 2'b11, 1);
        add(32, 0, 16'h0000, 2'b11, 2'b11, 1);
        add(33, 0, 16'h0000, 2'b00, 2'b11, 1);
        add(34, 0, 16'h0000, 2'b01, 2'b11, 1);
        add(35, 0, 16'h0000, 2'b00, 2'b11, 1);
        add(36, 0, 16'h0000, 2'b01, 2'b11, 1);
        add(37, 0, 16'h0000, 2'b10, 2'b11, 1);
        add(42, 1, 16'h0507, 2'b11, 2'b11, 1);
        add(43, 0, 16'h0000, 2'b00, 2'b11, 1);
        add(44, 0, 16'h0000, 2'b01, 2'b11, 1);
        add(46, 0, 16'h0000, 2'b00, 2'b11, 1);
        add(47, 0, 16'h0000, 2'b10, 2'b11, 1);
        add(50, 0, 16'h0000, 2'b00, 2'b11, 1);
        add(51, 0, 16'h0000, 2'b01, 2'b11, 1);
        add(52, 0, 16'h0000, 2'b10, 2'b11, 1);
        add(58, 0, 16'h0000, 2'b01, 2'b11, 1);
        for (int t = 0; t < 60; t++) begin
            dl = 1'b0;
            dv = '0;
            foreach (vecs[k]) begin
                if (vecs[k].cyc == cyc) begin
                    chk("tbl_cken",   32'(cken),      32'(vecs[k].cken));
                    chk("tbl_rst",    32'(rst_out_n), 32'(vecs[k].rst));
                    chk("tbl_locked", 32'(locked),    32'(vecs[k].lkd));
                    dl = vecs[k].dl;
                    dv = vecs[k].dv;
                end
            end
            tick(1'b1, dl, dv, 1'b0);
        end
    endtask

    // Three-cycle lock drop while running, then full relock
    task automatic run_lock_loss();
        int base;
        base = cyc;
        for (int t = 0; t < 34; t++) begin
            tick((t < 3) ? 1'b0 : 1'b1, 1'b0, 16'h0507, 1'b0);
            case (cyc - base)
                2: begin
                    chk("loss_pre_locked", 32'(locked),    32'd1);
                    chk("loss_pre_rst",    32'(rst_out_n), 32'd3);
                end
                3: begin
                    chk("loss_rst",    32'(rst_out_n),  32'd0);
                    chk("loss_cken",   32'(cken),       32'd0);
                    chk("loss_locked", 32'(locked),     32'd0);
                    chk("loss_flag",   32'(lock_lost),  32'd1);
                    chk("loss_count",  32'(loss_count), CNT_EN ? 32'd1 : 32'd0);
                end
                26: chk("relock_rst0",       32'(rst_out_n), 32'd1);
                29: chk("relock_pre_locked", 32'(locked),    32'd0);
                30: begin
                    chk("relock_locked", 32'(locked),    32'd1);
                    chk("relock_rst",    32'(rst_out_n), 32'd3);
                    chk("relock_flag",   32'(lock_lost), 32'd1);
                end
                default: ;
            endcase
        end
        tick(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("clr_flag",  32'(lock_lost),  32'd0);
        chk("clr_count", 32'(loss_count), 32'd0);
    endtask

    // One-cycle glitch during SETTLE at settle count 10
    task automatic run_settle_glitch();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            tick((t == 11) ? 1'b0 : 1'b1, 1'b0, 16'h0000, 1'b0);
            case (cyc)
                14: begin
                    chk("glitch_cken14", 32'(cken),      32'd0);
                    chk("glitch_flag",   32'(lock_lost), 32'd0);
                end
                15: chk("glitch_cken15",  32'(cken),      32'd0);
                16: chk("glitch_cken16",  32'(cken),      32'd3);
                34: chk("glitch_rst34",   32'(rst_out_n), 32'd0);
                35: chk("glitch_rst35",   32'(rst_out_n), 32'd1);
                38: chk("glitch_lock38",  32'(locked),    32'd0);
                39: begin
                    chk("glitch_lock39", 32'(locked),    32'd1);
                    chk("glitch_flag39", 32'(lock_lost), 32'd0);
                end
                default: ;
            endcase
        end
    endtask

    // Reset pulse in the middle of the release stagger
    task automatic run_reset_mid_release();
        do_reset();
        for (int t = 0; t < 24; t++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("midrel_rst_before", 32'(rst_out_n), 32'd1);
        do_reset();
        for (int t = 0; t < 10; t++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("midrel_rst_after", 32'(rst_out_n), 32'd0);
        chk("midrel_locked",    32'(locked),    32'd0);
    endtask

    // Repeated losses drive the counter into saturation
    task automatic run_saturation();
        for (int n = 0; n < 258; n++) begin
            for (int t = 0; t < 30; t++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
            tick(1'b0, 1'b0, 16'h0000, 1'b0);
            tick(1'b0, 1'b0, 16'h0000, 1'b0);
        end
        for (int t = 0; t < 3; t++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("sat_count", 32'(loss_count), CNT_EN ? 32'd255 : 32'd0);
        chk("sat_flag",  32'(lock_lost),  32'd1);
    endtask

    task automatic run_random();
        int          drop;
        logic        pl;
        logic        dl;
        logic        clr;
        logic [15:0] dv;
        drop = 0;
        do_reset();
        for (int t = 0; t < 5000; t++) begin
            if (drop > 0) drop--;
            else if ($urandom_range(0, 119) == 0) drop = $urandom_range(1, 4);
            pl  = (drop == 0);
            dl  = ($urandom_range(0, 15) == 0);
            dv  = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1499) == 0) do_reset();
            tick(pl, dl, dv, clr);
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        run_table();
        run_lock_loss();
        run_settle_glitch();
        run_reset_mid_release();
        run_saturation();
        run_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
